// File: rtl/diamond_pkg.sv
// rtl/diamond_pkg.sv - shared widths, ALU opcode enum and register-index helpers
package diamond_pkg;

    // Default datapath width of operands and results.
    localparam int XLEN = 32;

    // Architectural register index width (x0..x31).
    localparam int REG_AW = 5;

    // Width of the ALU operation code.
    localparam int ALU_OPW = 5;

    // ALU operation codes. Codes not listed here are still legal to carry
    // through the pipeline; the ALU decides what to do with them.
    typedef enum logic [ALU_OPW-1:0] {
        ALU_ADD      = 5'b00000,
        ALU_SUB      = 5'b00001,
        ALU_SLL      = 5'b00010,
        ALU_SLT      = 5'b00011,
        ALU_SLTU     = 5'b00100,
        ALU_XOR      = 5'b00101,
        ALU_SRL      = 5'b00110,
        ALU_SRA      = 5'b00111,
        ALU_OR       = 5'b01000,
        ALU_AND      = 5'b01001,
        ALU_LUI      = 5'b01010,
        ALU_AUIPC    = 5'b01011,
        ALU_BEQ      = 5'b01100,
        ALU_BNE      = 5'b01101,
        ALU_BLT      = 5'b01110,
        ALU_BGE      = 5'b01111,
        ALU_BLTU     = 5'b10000,
        ALU_BGEU     = 5'b10001,
        ALU_JAL_JALR = 5'b11111
    } alu_op_e;

    // True when a written register index names the same, non-zero register as
    // a read index. x0 is hardwired to zero and never takes part in bypassing
    // or hazard detection.
    function automatic logic reg_hit(input logic [REG_AW-1:0] wr_addr,
                                     input logic [REG_AW-1:0] rd_addr);
        return (wr_addr != '0) && (wr_addr == rd_addr);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - per-operand bypass select between exm bus, wb bus and register file
module fwd_mux #(
    parameter int XLEN = diamond_pkg::XLEN
) (
    input  logic [diamond_pkg::REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]                rf_data,
    input  logic [diamond_pkg::REG_AW-1:0] exm_rd_addr,
    input  logic                           exm_rd_we,
    input  logic [XLEN-1:0]                exm_rd_data,
    input  logic [diamond_pkg::REG_AW-1:0] wb_rd_addr,
    input  logic                           wb_rd_we,
    input  logic [XLEN-1:0]                wb_rd_data,
    output logic [XLEN-1:0]                fwd_data
);
    import diamond_pkg::*;

    logic exm_hit;
    logic wb_hit;

    // The stage right after EX holds the youngest result, so it wins over
    // writeback when both target the same register.
    always_comb begin
        exm_hit  = exm_rd_we && reg_hit(exm_rd_addr, rs_addr);
        wb_hit   = wb_rd_we && reg_hit(wb_rd_addr, rs_addr);
        fwd_data = rf_data;
        if (exm_hit) begin
            fwd_data = exm_rd_data;
        end else if (wb_hit) begin
            fwd_data = wb_rd_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand bypass and load-use stall
module id_ex_stage #(
    parameter int XLEN = diamond_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    // Decode side
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic            id_use_imm_i,
    input  logic [4:0]      id_alu_op_i,
    input  logic [4:0]      id_rd_addr_i,
    input  logic            id_rd_we_i,
    input  logic            id_is_load_i,

    // Kill whatever sits in the EX register (taken branch/jump)
    input  logic            flush_i,

    // Result bus of the stage after EX
    input  logic [4:0]      exm_rd_addr_i,
    input  logic            exm_rd_we_i,
    input  logic [XLEN-1:0] exm_rd_data_i,

    // Writeback bus
    input  logic [4:0]      wb_rd_addr_i,
    input  logic            wb_rd_we_i,
    input  logic [XLEN-1:0] wb_rd_data_i,

    // ALU side
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_a_o,
    output logic [XLEN-1:0] ex_b_o,
    output logic [4:0]      ex_alu_op_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic            ex_rd_we_o,
    output logic            ex_is_load_o,
    output logic            stall_o
);
    import diamond_pkg::*;

    logic            advance;
    logic            hazard;
    logic            capture;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] op_b_next;

    // Bypassed value of source operand 1.
    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr     (id_rs1_addr_i),
        .rf_data     (id_rs1_data_i),
        .exm_rd_addr (exm_rd_addr_i),
        .exm_rd_we   (exm_rd_we_i),
        .exm_rd_data (exm_rd_data_i),
        .wb_rd_addr  (wb_rd_addr_i),
        .wb_rd_we    (wb_rd_we_i),
        .wb_rd_data  (wb_rd_data_i),
        .fwd_data    (rs1_fwd)
    );

    // Bypassed value of source operand 2.
    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr     (id_rs2_addr_i),
        .rf_data     (id_rs2_data_i),
        .exm_rd_addr (exm_rd_addr_i),
        .exm_rd_we   (exm_rd_we_i),
        .exm_rd_data (exm_rd_data_i),
        .wb_rd_addr  (wb_rd_addr_i),
        .wb_rd_we    (wb_rd_we_i),
        .wb_rd_data  (wb_rd_data_i),
        .fwd_data    (rs2_fwd)
    );

    // Handshake and load-use detection. A load in EX has no result on any
    // bypass bus yet, so a dependent instruction must wait one slot; rs2 only
    // counts when it is actually used as operand B.
    always_comb begin
        advance    = !ex_valid_o || ex_ready_i;
        hazard     = ex_valid_o && ex_is_load_o && ex_rd_we_o &&
                     (reg_hit(ex_rd_addr_o, id_rs1_addr_i) ||
                      (!id_use_imm_i && reg_hit(ex_rd_addr_o, id_rs2_addr_i)));
        id_ready_o = advance && !hazard && !flush_i;
        stall_o    = id_valid_i && hazard;
        capture    = id_valid_i && id_ready_o;
        op_b_next  = id_use_imm_i ? id_imm_i : rs2_fwd;
    end

    // Control bits: flush kills the slot even while the ALU is stalled,
    // otherwise take a new instruction, insert a bubble, or hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_o   <= 1'b0;
            ex_rd_we_o   <= 1'b0;
            ex_is_load_o <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o   <= 1'b0;
            ex_rd_we_o   <= 1'b0;
            ex_is_load_o <= 1'b0;
        end else if (capture) begin
            ex_valid_o   <= 1'b1;
            ex_rd_we_o   <= id_rd_we_i;
            ex_is_load_o <= id_is_load_i;
        end else if (advance) begin
            ex_valid_o   <= 1'b0;
            ex_rd_we_o   <= 1'b0;
        end
    end

    // Payload: operands and opcode only change on a capture, so the bypass
    // buses are sampled exactly once per instruction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_a_o       <= '0;
            ex_b_o       <= '0;
            ex_alu_op_o  <= ALU_ADD;
            ex_rd_addr_o <= '0;
        end else if (capture) begin
            ex_a_o       <= rs1_fwd;
            ex_b_o       <= op_b_next;
            ex_alu_op_o  <= id_alu_op_i;
            ex_rd_addr_o <= id_rd_addr_i;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            id_valid_i;
    logic            id_ready_o;
    logic [4:0]      id_rs1_addr_i, id_rs2_addr_i;
    logic [XLEN-1:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic            id_use_imm_i;
    logic [4:0]      id_alu_op_i, id_rd_addr_i;
    logic            id_rd_we_i, id_is_load_i;
    logic            flush_i;
    logic [4:0]      exm_rd_addr_i, wb_rd_addr_i;
    logic            exm_rd_we_i, wb_rd_we_i;
    logic [XLEN-1:0] exm_rd_data_i, wb_rd_data_i;
    logic            ex_valid_o, ex_ready_i;
    logic [XLEN-1:0] ex_a_o, ex_b_o;
    logic [4:0]      ex_alu_op_o, ex_rd_addr_o;
    logic            ex_rd_we_o, ex_is_load_o, stall_o;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_use_imm_i(id_use_imm_i),
        .id_alu_op_i(id_alu_op_i), .id_rd_addr_i(id_rd_addr_i),
        .id_rd_we_i(id_rd_we_i), .id_is_load_i(id_is_load_i),
        .flush_i(flush_i),
        .exm_rd_addr_i(exm_rd_addr_i), .exm_rd_we_i(exm_rd_we_i), .exm_rd_data_i(exm_rd_data_i),
        .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_we_i(wb_rd_we_i), .wb_rd_data_i(wb_rd_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_alu_op_o(ex_alu_op_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_we_o(ex_rd_we_o),
        .ex_is_load_o(ex_is_load_o), .stall_o(stall_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference view of the EX slot: what instruction the stage holds.
    logic            m_valid, m_we, m_load;
    logic [XLEN-1:0] m_a, m_b;
    logic [4:0]      m_op, m_rd;
    logic            obs_ready, obs_stall;

    typedef struct {
        logic [4:0]      rs1, rs2;
        logic [XLEN-1:0] d1, d2, imm;
        logic            use_imm;
        logic [4:0]      op, rd;
        logic [4:0]      exm_a;
        logic            exm_we;
        logic [XLEN-1:0] exm_d;
        logic [4:0]      wb_a;
        logic            wb_we;
        logic [XLEN-1:0] wb_d;
        logic [XLEN-1:0] exp_a, exp_b;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [XLEN-1:0] bypass(input logic [4:0] a, input logic [XLEN-1:0] rf);
        if (a == 0) return rf;
        if (exm_rd_we_i && exm_rd_addr_i == a) return exm_rd_data_i;
        if (wb_rd_we_i && wb_rd_addr_i == a) return wb_rd_data_i;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_load = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
    endtask

    // Called at posedge+1 with inputs set; checks handshake before the edge
    // and the EX slot after it.
    task automatic cycle();
        logic adv, haz, rdy;
        #1;
        adv = !m_valid || ex_ready_i;
        haz = m_valid && m_load && m_we && m_rd != 0 &&
              (id_rs1_addr_i == m_rd || (!id_use_imm_i && id_rs2_addr_i == m_rd));
        rdy = adv && !haz && !flush_i;
        obs_ready = id_ready_o;
        obs_stall = stall_o;
        chk("id_ready", id_ready_o, rdy);
        chk("stall", stall_o, id_valid_i && haz);
        if (flush_i) begin
            m_valid = 0; m_we = 0; m_load = 0;
        end else if (id_valid_i && rdy) begin
            m_valid = 1;
            m_a     = bypass(id_rs1_addr_i, id_rs1_data_i);
            m_b     = id_use_imm_i ? id_imm_i : bypass(id_rs2_addr_i, id_rs2_data_i);
            m_op    = id_alu_op_i;
            m_rd    = id_rd_addr_i;
            m_we    = id_rd_we_i;
            m_load  = id_is_load_i;
        end else if (adv) begin
            m_valid = 0; m_we = 0;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", ex_valid_o, m_valid);
        chk("ex_rd_we", ex_rd_we_o, m_we);
        if (m_valid) begin
            chk("ex_a", ex_a_o, m_a);
            chk("ex_b", ex_b_o, m_b);
            chk("ex_alu_op", ex_alu_op_o, m_op);
            chk("ex_rd_addr", ex_rd_addr_o, m_rd);
            chk("ex_is_load", ex_is_load_o, m_load);
        end
    endtask

    task automatic clr_bus();
        exm_rd_addr_i = 0; exm_rd_we_i = 0; exm_rd_data_i = '0;
        wb_rd_addr_i = 0; wb_rd_we_i = 0; wb_rd_data_i = '0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                             input logic [4:0] rd, input logic ld);
        id_valid_i = 1; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = '0; id_use_imm_i = 0;
        id_alu_op_i = 5'b00000; id_rd_addr_i = rd; id_rd_we_i = 1; id_is_load_i = ld;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, ex_valid_o, 1'b0);
        chk({tag, "_rd_we"}, ex_rd_we_o, 1'b0);
        chk({tag, "_is_load"}, ex_is_load_o, 1'b0);
        chk({tag, "_a"}, ex_a_o, 32'h0);
        chk({tag, "_b"}, ex_b_o, 32'h0);
        chk({tag, "_op"}, ex_alu_op_o, 5'b00000);
        chk({tag, "_rd"}, ex_rd_addr_o, 5'd0);
    endtask

    initial begin
        rst_ni = 0; flush_i = 0; ex_ready_i = 1;
        set_instr(0, 0, '0, '0, 0, 0);
        id_valid_i = 0;
        clr_bus();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        chk("rst_id_ready", id_ready_o, 1'b1);
        rst_ni = 1;

        // Table: back-to-back captures with bypass cases, all non-loads.
        vecs[0] = '{5'd5, 5'd6, 32'h0, 32'h22, 32'h0, 1'b0, 5'b00000, 5'd9,
                    5'd5, 1'b1, 32'h10, 5'd0, 1'b0, 32'h0, 32'h10, 32'h22};
        vecs[1] = '{5'd1, 5'd7, 32'h11, 32'h77, 32'h0, 1'b0, 5'b00000, 5'd8,
                    5'd7, 1'b1, 32'hA, 5'd7, 1'b1, 32'hB, 32'h11, 32'hA};
        vecs[2] = '{5'd0, 5'd0, 32'h5, 32'h6, 32'h0, 1'b0, 5'b00001, 5'd2,
                    5'd0, 1'b1, 32'hA, 5'd0, 1'b1, 32'hB, 32'h5, 32'h6};
        vecs[3] = '{5'd9, 5'd10, 32'h1, 32'h2, 32'h0, 1'b0, 5'b00010, 5'd3,
                    5'd8, 1'b1, 32'hDEAD, 5'd9, 1'b1, 32'hBEEF, 32'hBEEF, 32'h2};
        vecs[4] = '{5'd4, 5'd4, 32'h3, 32'h3, 32'h0, 1'b0, 5'b00011, 5'd4,
                    5'd4, 1'b0, 32'h123, 5'd4, 1'b1, 32'h456, 32'h456, 32'h456};
        vecs[5] = '{5'd2, 5'd3, 32'h20, 32'h30, 32'hFFFF_FFF0, 1'b1, 5'b00100, 5'd6,
                    5'd3, 1'b1, 32'h99, 5'd2, 1'b1, 32'h88, 32'h88, 32'hFFFF_FFF0};
        vecs[6] = '{5'd11, 5'd12, 32'hA5A5, 32'h5A5A, 32'h0, 1'b0, 5'b11111, 5'd1,
                    5'd11, 1'b1, 32'h1, 5'd12, 1'b1, 32'h2, 32'h1, 32'h2};
        vecs[7] = '{5'd13, 5'd14, 32'h7, 32'h8, 32'h40, 1'b0, 5'b10110, 5'd31,
                    5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h7, 32'h8};
        for (int i = 0; i < 8; i++) begin
            set_instr(vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2, vecs[i].rd, 0);
            id_imm_i = vecs[i].imm; id_use_imm_i = vecs[i].use_imm; id_alu_op_i = vecs[i].op;
            exm_rd_addr_i = vecs[i].exm_a; exm_rd_we_i = vecs[i].exm_we; exm_rd_data_i = vecs[i].exm_d;
            wb_rd_addr_i = vecs[i].wb_a; wb_rd_we_i = vecs[i].wb_we; wb_rd_data_i = vecs[i].wb_d;
            cycle();
            chk($sformatf("vec%0d_a", i), ex_a_o, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), ex_b_o, vecs[i].exp_b);
            chk($sformatf("vec%0d_op", i), ex_alu_op_o, vecs[i].op);
            chk($sformatf("vec%0d_rd", i), ex_rd_addr_o, vecs[i].rd);
        end
        clr_bus();

        // Load-use: LW x3 then ADD rs1=x3 stalls one slot, then captures.
        set_instr(1, 2, 32'h1, 32'h2, 3, 1);
        cycle();
        chk("lu_load_in_ex", ex_is_load_o, 1'b1);
        set_instr(3, 2, 32'h0, 32'h2, 4, 0);
        cycle();
        chk("lu_stall", obs_stall, 1'b1);
        chk("lu_ready", obs_ready, 1'b0);
        chk("lu_bubble", ex_valid_o, 1'b0);
        exm_rd_addr_i = 3; exm_rd_we_i = 1; exm_rd_data_i = 32'h55;
        cycle();
        chk("lu_stall_gone", obs_stall, 1'b0);
        chk("lu_capture", ex_valid_o, 1'b1);
        chk("lu_fwd_a", ex_a_o, 32'h55);
        clr_bus();

        // ALU backpressure for three cycles.
        set_instr(1, 2, 32'h101, 32'h2, 9, 0);
        cycle();
        set_instr(1, 2, 32'h202, 32'h3, 10, 0);
        ex_ready_i = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_ready", obs_ready, 1'b0);
            chk("bp_hold_a", ex_a_o, 32'h101);
            chk("bp_hold_valid", ex_valid_o, 1'b1);
        end
        ex_ready_i = 1;
        cycle();
        chk("bp_release_ready", obs_ready, 1'b1);
        chk("bp_release_a", ex_a_o, 32'h202);

        // Flush beats a valid decode-side instruction.
        set_instr(5, 6, 32'h303, 32'h4, 11, 0);
        cycle();
        set_instr(5, 6, 32'h404, 32'h5, 12, 0);
        flush_i = 1;
        cycle();
        chk("fl_ready", obs_ready, 1'b0);
        chk("fl_valid", ex_valid_o, 1'b0);
        flush_i = 0; id_valid_i = 0;
        cycle();
        chk("fl_not_taken", ex_valid_o, 1'b0);

        // Reset pulse while a load-use stall is in progress.
        set_instr(1, 2, 32'h7, 32'h8, 3, 1);
        cycle();
        set_instr(3, 0, 32'h0, 32'h0, 4, 0);
        #1;
        chk("rs_stall_before", stall_o, 1'b1);
        #1;
        rst_ni = 0;
        #1;
        chk_reset_outputs("rs");
        chk("rs_stall", stall_o, 1'b0);
        model_reset();
        @(posedge clk);
        #2;
        rst_ni = 1;
        @(posedge clk);
        #1;
        id_valid_i = 0;
        cycle();
        chk("rs_ready_after", obs_ready, 1'b1);

        // Randomised traffic against the reference view.
        for (int n = 0; n < 400; n++) begin
            id_valid_i    = ($urandom_range(0, 3) != 0);
            id_rs1_addr_i = 5'($urandom_range(0, 3));
            id_rs2_addr_i = 5'($urandom_range(0, 3));
            id_rs1_data_i = $urandom;
            id_rs2_data_i = $urandom;
            id_imm_i      = $urandom;
            id_use_imm_i  = 1'($urandom_range(0, 1));
            id_alu_op_i   = 5'($urandom_range(0, 31));
            id_rd_addr_i  = 5'($urandom_range(0, 3));
            id_rd_we_i    = ($urandom_range(0, 3) != 0);
            id_is_load_i  = ($urandom_range(0, 2) == 0);
            flush_i       = ($urandom_range(0, 7) == 0);
            ex_ready_i    = ($urandom_range(0, 3) != 0);
            exm_rd_addr_i = 5'($urandom_range(0, 3));
            exm_rd_we_i   = 1'($urandom_range(0, 1));
            exm_rd_data_i = $urandom;
            wb_rd_addr_i  = 5'($urandom_range(0, 3));
            wb_rd_we_i    = 1'($urandom_range(0, 1));
            wb_rd_data_i  = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
